uart_wb_fifo: RTL and testbench

Parametrised UART with TX and RX FIFOs, a programmable baud divisor, and sticky error flags. Sits on the same 2-bit-address, 8-bit-data bus as the existing uart. It is a drop-in successor, except that the bus is synchronous to clk: there is no separate bus clock. Buffering lets the host burst up to FIFO_DEPTH bytes without polling per character.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 42 ++++
 rtl/uart_wb_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_wb_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, status/control bit positions and engine state encodings
// for the FIFO-buffered UART.
package uart_pkg;
    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STAT  = 2'd1;
    localparam logic [1:0] ADDR_DIVLO = 2'd2;
    localparam logic [1:0] ADDR_DIVHI = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_BUSY   = 6;
    localparam int ST_TX_DROP   = 7;

    localparam int CTRL_TX_IE    = 0;
    localparam int CTRL_FLUSH_TX = 1;
    localparam int CTRL_FLUSH_RX = 2;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_wb_fifo.sv
// UART with TX/RX FIFOs, programmable divisor and sticky error flags on a
// 2-bit-address byte bus that runs on the UART clock.
module uart_wb_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tx_bit,
    input  logic       rx_bit,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_stb,
    output logic       wb_ack,
    output logic       irq
);
    localparam logic [15:0] DIV_RST = clamp_div(16'(CLK_HZ / BAUD));

    logic        access, rd_acc, wr_acc, stat_rd;
    logic [15:0] div;
    logic        tx_ie, tx_drop, rx_overrun, frame_err;
    logic [7:0]  status;

    logic                 tx_push, tx_pop, tx_full, tx_empty, flush_tx;
    logic                 rx_push, rx_pop, rx_full, rx_empty, flush_rx, ferr_set;
    logic [DATA_BITS-1:0] tx_dout, rx_dout;

    tx_state_t            tx_state, tx_next;
    logic [15:0]          tx_cnt, tx_div;
    logic [DATA_BITS-1:0] tx_sh;
    logic [3:0]           tx_bitn;
    logic                 tx_done, tx_busy;

    rx_state_t            rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_prev, rx_tick;
    logic [15:0]          rx_cnt, rx_div;
    logic [DATA_BITS-1:0] rx_sh;
    logic [3:0]           rx_bitn;

    // The access fires on the edge that registers ack, so one side effect per ack.
    assign access   = wb_stb && !wb_ack;
    assign rd_acc   = access && !wb_we;
    assign wr_acc   = access && wb_we;
    assign stat_rd  = rd_acc && (wb_addr == ADDR_STAT);
    assign tx_push  = wr_acc && (wb_addr == ADDR_DATA);
    assign rx_pop   = rd_acc && (wb_addr == ADDR_DATA) && !rx_empty;
    assign flush_tx = wr_acc && (wb_addr == ADDR_STAT) && wb_data_in[CTRL_FLUSH_TX];
    assign flush_rx = wr_acc && (wb_addr == ADDR_STAT) && wb_data_in[CTRL_FLUSH_RX];
    assign tx_busy  = (tx_state != TX_IDLE);
    assign irq      = !rx_empty || (tx_empty && tx_ie);

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_RX_OVR]    = rx_overrun;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_TX_DROP]   = tx_drop;
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(flush_tx),
        .din(wb_data_in[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(flush_rx),
        .din(rx_sh), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            tx_ie       <= 1'b0;
            div         <= DIV_RST;
            tx_drop     <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wb_ack      <= access;
            wb_data_out <= '0;
            if (rd_acc) begin
                case (wb_addr)
                    ADDR_DATA:  wb_data_out <= rx_empty ? 8'h00 : 8'(rx_dout);
                    ADDR_STAT:  wb_data_out <= status;
                    ADDR_DIVLO: wb_data_out <= div[7:0];
                    default:    wb_data_out <= div[15:8];
                endcase
            end
            if (wr_acc) begin
                case (wb_addr)
                    ADDR_STAT:  tx_ie <= wb_data_in[CTRL_TX_IE];
                    ADDR_DIVLO: div   <= clamp_div({div[15:8], wb_data_in});
                    ADDR_DIVHI: div   <= clamp_div({wb_data_in, div[7:0]});
                    default:    ;
                endcase
            end
            // A new flag event outranks the clear-on-read of STATUS.
            tx_drop    <= (tx_push && tx_full && !tx_pop) || (tx_drop && !stat_rd);
            rx_overrun <= (rx_push && rx_full && !rx_pop) || (rx_overrun && !stat_rd);
            frame_err  <= ferr_set || (frame_err && !stat_rd);
        end
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_bit  = 1'b1;
        tx_done = (tx_cnt == tx_div - 16'd1);
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_next = TX_START;
                tx_pop  = 1'b1;
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_done) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_bit = tx_sh[0];
                if (tx_done && tx_bitn == 4'(DATA_BITS-1)) tx_next = TX_STOP;
            end
            TX_STOP: if (tx_done) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RST;
            tx_sh    <= '0;
            tx_bitn  <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == TX_IDLE || tx_done) ? 16'd0 : tx_cnt + 16'd1;
            if (tx_pop) begin
                tx_div  <= div;
                tx_sh   <= tx_dout;
                tx_bitn <= '0;
            end else if (tx_state == TX_DATA && tx_done) begin
                tx_sh   <= tx_sh >> 1;
                tx_bitn <= tx_bitn + 4'd1;
            end
        end
    end

    // START counts from the edge cycle, so its tick lands mid start-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1))
                                            : (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_next  = rx_state;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bitn == 4'(DATA_BITS-1)) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) begin
                rx_next  = RX_IDLE;
                rx_push  = rx_s2;
                ferr_set = !rx_s2;
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RST;
            rx_sh    <= '0;
            rx_bitn  <= '0;
        end else begin
            rx_s1    <= rx_bit;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_cnt  <= 16'd1;
                rx_div  <= div;
                rx_bitn <= '0;
            end else begin
                rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
                if (rx_state == RX_DATA && rx_tick) begin
                    rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_bitn <= rx_bitn + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_wb_fifo.sv
// Self-checking bench: register vector table, loopback frames checked against
// a bit-level frame model, RX overrun/framing sequences, burst and reset.
module tb_uart_wb_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tx_bit, rx_bit, wb_we, wb_stb, wb_ack, irq;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in, wb_data_out;
    logic       loopback, rx_drv;
    int         cyc = 0;
    int         pass_n = 0;
    int         total_n = 0;

    typedef struct {
        logic [1:0] a;
        logic       we;
        logic [7:0] d;
        logic [7:0] exp;
        logic       irq_exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rx_bit = loopback ? tx_bit : rx_drv;

    uart_wb_fifo #(.CLK_HZ(12000000), .BAUD(115200), .FIFO_DEPTH(16), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .tx_bit(tx_bit), .rx_bit(rx_bit),
        .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq)
    );

    task automatic check(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus(input logic [1:0] a, input logic we, input logic [7:0] d,
                       output logic [7:0] q);
        int n;
        n = 0;
        wb_addr = a; wb_we = we; wb_data_in = d; wb_stb = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack && n < 4);
        if (!wb_ack) check("ack_timeout", 0, 1);
        q = wb_data_out;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(a, 1'b1, d, q);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] q;
        bus(a, 1'b0, 8'h00, q);
        check(name, q, exp);
    endtask

    // Expected frame: start 0, eight data bits LSB first, stop 1; each bit div clocks.
    task automatic frame_chk(input logic [7:0] b, input int div, input int nd);
        int s, n, e;
        n = 0;
        while (tx_bit !== 1'b0 && n < 64) begin step(1); n++; end
        if (tx_bit !== 1'b0) begin
            check("tx_start_timeout", 1, 0);
            return;
        end
        s = cyc;
        for (int i = 0; i < 10; i++) begin
            e = (i == 0) ? 0 : (i == 9) ? 1 : int'((b >> (i - 1)) & 8'h01);
            while (cyc < s + i * div + div / 2) step(1);
            check($sformatf("tx_%02h_bit%0d", b, i), int'(tx_bit), e);
            if (i == 1 && nd != 0) wr(ADDR_DIVLO, 8'(nd));
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int div);
        rx_drv = 1'b0; step(div);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; step(div); end
        rx_drv = stop; step(div);
        rx_drv = 1'b1;
    endtask

    function automatic void add(input logic [1:0] a, input logic we, input logic [7:0] d,
                                input logic [7:0] exp, input logic irq_exp);
        vec_t v;
        v.a = a; v.we = we; v.d = d; v.exp = exp; v.irq_exp = irq_exp;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        logic [7:0] b;
        int         d;
        logic [7:0] rxq[$];

        reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data_in = '0;
        loopback = 1'b0; rx_drv = 1'b1;
        step(3);
        check("reset_tx_bit", int'(tx_bit), 1);
        check("reset_ack", int'(wb_ack), 0);
        check("reset_dout", int'(wb_data_out), 0);
        reset = 1'b0;
        step(1);

        // Register map vectors: divisor readback and clamp, CTRL tx_ie and irq.
        add(ADDR_STAT,  1'b0, 8'h00, 8'h06, 1'b0);
        add(ADDR_DIVLO, 1'b0, 8'h00, 8'h68, 1'b0);
        add(ADDR_DIVHI, 1'b0, 8'h00, 8'h00, 1'b0);
        add(ADDR_DATA,  1'b0, 8'h00, 8'h00, 1'b0);
        add(ADDR_DIVLO, 1'b1, 8'h02, 8'h00, 1'b0);
        add(ADDR_DIVLO, 1'b0, 8'h00, 8'h04, 1'b0);
        add(ADDR_DIVHI, 1'b0, 8'h00, 8'h00, 1'b0);
        add(ADDR_DIVHI, 1'b1, 8'h01, 8'h00, 1'b0);
        add(ADDR_DIVLO, 1'b0, 8'h00, 8'h04, 1'b0);
        add(ADDR_DIVHI, 1'b0, 8'h00, 8'h01, 1'b0);
        add(ADDR_DIVLO, 1'b1, 8'h00, 8'h00, 1'b0);
        add(ADDR_DIVLO, 1'b0, 8'h00, 8'h00, 1'b0);
        add(ADDR_DIVHI, 1'b0, 8'h00, 8'h01, 1'b0);
        add(ADDR_DIVHI, 1'b1, 8'h00, 8'h00, 1'b0);
        add(ADDR_DIVLO, 1'b0, 8'h00, 8'h04, 1'b0);
        add(ADDR_STAT,  1'b1, 8'h01, 8'h00, 1'b1);
        add(ADDR_STAT,  1'b0, 8'h00, 8'h06, 1'b1);
        add(ADDR_STAT,  1'b1, 8'h00, 8'h00, 1'b0);
        add(ADDR_STAT,  1'b1, 8'h06, 8'h00, 1'b0);
        add(ADDR_STAT,  1'b0, 8'h00, 8'h06, 1'b0);
        foreach (tbl[i]) begin
            bus(tbl[i].a, tbl[i].we, tbl[i].d, q);
            if (!tbl[i].we) check($sformatf("vec%0d_rd", i), q, tbl[i].exp);
            check($sformatf("vec%0d_irq", i), int'(irq), int'(tbl[i].irq_exp));
        end

        // Loopback of 0x41 at 4 clocks per bit.
        loopback = 1'b1;
        wr(ADDR_DIVLO, 8'd4);
        wr(ADDR_DATA, 8'h41);
        frame_chk(8'h41, 4, 0);
        step(12);
        rd_chk("lb_stat_rx", ADDR_STAT, 8'h02);
        rd_chk("lb_data", ADDR_DATA, 8'h41);
        rd_chk("lb_stat_empty", ADDR_STAT, 8'h06);

        // Random bytes at random divisors, looped back.
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(4, 12);
            b = 8'($urandom_range(0, 255));
            wr(ADDR_DIVLO, 8'(d));
            wr(ADDR_DATA, b);
            frame_chk(b, d, 0);
            step(2 * d + 6);
            rd_chk($sformatf("rand%0d_data", k), ADDR_DATA, b);
        end

        // Divisor change mid-frame applies from the next frame on.
        wr(ADDR_DIVLO, 8'd4);
        wr(ADDR_DATA, 8'hA5);
        frame_chk(8'hA5, 4, 8);
        wr(ADDR_DATA, 8'h3C);
        frame_chk(8'h3C, 8, 0);
        step(30);
        rd_chk("divchg_a", ADDR_DATA, 8'hA5);
        rd_chk("divchg_b", ADDR_DATA, 8'h3C);
        rd_chk("divchg_stat", ADDR_STAT, 8'h06);

        // RX overrun: 17 frames, no reads; the first 16 are kept.
        loopback = 1'b0;
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k < 16) rxq.push_back(b);
            drive_frame(b, 1'b1, 8);
        end
        step(10);
        check("ovr_irq", int'(irq), 1);
        rd_chk("ovr_stat", ADDR_STAT, 8'h1A);
        rd_chk("ovr_stat_clr", ADDR_STAT, 8'h0A);
        for (int k = 0; k < 16; k++) rd_chk($sformatf("ovr_rd%0d", k), ADDR_DATA, rxq.pop_front());
        rd_chk("ovr_stat_empty", ADDR_STAT, 8'h06);

        // Framing error, then a short glitch that must be ignored.
        drive_frame(8'h55, 1'b0, 8);
        step(10);
        rd_chk("ferr_stat", ADDR_STAT, 8'h26);
        rd_chk("ferr_clr", ADDR_STAT, 8'h06);
        rx_drv = 1'b0; step(2); rx_drv = 1'b1;
        step(40);
        rd_chk("glitch_stat", ADDR_STAT, 8'h06);
        rd_chk("glitch_data", ADDR_DATA, 8'h00);

        // Burst: first byte is taken by the engine, 16 more fill the FIFO, 18th drops.
        wr(ADDR_DIVLO, 8'hFF);
        wr(ADDR_DATA, 8'h00);
        for (int k = 1; k <= 16; k++) wr(ADDR_DATA, 8'(k));
        rd_chk("burst_full", ADDR_STAT, 8'h45);
        wr(ADDR_DATA, 8'h11);
        rd_chk("burst_drop", ADDR_STAT, 8'hC5);
        rd_chk("burst_drop_clr", ADDR_STAT, 8'h45);
        wr(ADDR_STAT, 8'h02);
        rd_chk("flush_tx", ADDR_STAT, 8'h46);
        step(300);
        check("mid_data_tx_bit", int'(tx_bit), 0);

        // Reset in the middle of the data phase.
        reset = 1'b1;
        step(1);
        check("rst_tx_bit", int'(tx_bit), 1);
        reset = 1'b0;
        rd_chk("rst_stat", ADDR_STAT, 8'h06);
        rd_chk("rst_divlo", ADDR_DIVLO, 8'h68);
        rd_chk("rst_divhi", ADDR_DIVHI, 8'h00);
        check("rst_irq", int'(irq), 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
